// File: rtl/fft_butterfly_datapath.sv
`default_nettype none
// ============================================================================
// fft_butterfly_datapath : 4-stage radix-2 DIT butterfly for a 32-point
// in-place FFT. Optional macro FFT_BFLY_SCALE_EN halves every output.
// Revision 1.0
// ============================================================================
module fft_butterfly_datapath #(
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      mema_address,
    input  logic [4:0]      memb_address,
    input  logic [3:0]      twiddle_address,
    input  logic            mem_write,
    input  logic            fft_done,
    output logic [4:0]      rd_addr_a,
    output logic [4:0]      rd_addr_b,
    input  logic [2*DW-1:0] rd_data_a,
    input  logic [2*DW-1:0] rd_data_b,
    output logic            wr_en,
    output logic [4:0]      wr_addr_a,
    output logic [4:0]      wr_addr_b,
    output logic [2*DW-1:0] wr_data_a,
    output logic [2*DW-1:0] wr_data_b,
    output logic            busy,
    output logic            done
);

`ifdef FFT_BFLY_SCALE_EN
    localparam int SH = 1;
`else
    localparam int SH = 0;
`endif
    localparam logic signed [DW+TW:0] RND = (DW+TW+1)'(1) <<< (TW-2);

    // Q1.15 table of W[k] = exp(-j*2*pi*k/32); widened for TW > 16
    localparam logic signed [15:0] ROM_RE [16] = '{
        16'sd32767, 16'sd32137, 16'sd30273, 16'sd27245,
        16'sd23170, 16'sd18204, 16'sd12539, 16'sd6393,
        16'sd0, -16'sd6393, -16'sd12539, -16'sd18204,
        -16'sd23170, -16'sd27245, -16'sd30273, -16'sd32137};
    localparam logic signed [15:0] ROM_IM [16] = '{
        16'sd0, -16'sd6393, -16'sd12540, -16'sd18205,
        -16'sd23170, -16'sd27246, -16'sd30274, -16'sd32138,
        16'sh8000, -16'sd32138, -16'sd30274, -16'sd27246,
        -16'sd23170, -16'sd18205, -16'sd12540, -16'sd6393};

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t state_q, state_d;
    logic [1:0] drain_cnt_q, drain_cnt_d;
    logic fft_done_q, fft_done_d;
    logic fd_rise;

    logic v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, wr_en_q, wr_en_d;
    logic [4:0] ma0_q, ma0_d, mb0_q, mb0_d, ma1_q, ma1_d, mb1_q, mb1_d;
    logic [4:0] ma2_q, ma2_d, mb2_q, mb2_d;
    logic [4:0] wr_addr_a_q, wr_addr_a_d, wr_addr_b_q, wr_addr_b_d;
    logic [3:0] k0_q, k0_d;
    logic [2*DW-1:0] a1_q, a1_d, b1_q, b1_d, a2_q, a2_d;
    logic [2*DW-1:0] wr_data_a_q, wr_data_a_d, wr_data_b_q, wr_data_b_d;
    logic signed [TW-1:0] twr_q, twr_d, twi_q, twi_d;
    logic signed [DW+TW-1:0] prr_q, prr_d, pii_q, pii_d, pri_q, pri_d, pir_q, pir_d;
    logic signed [DW+1:0] t_re, t_im, sum_re, sum_im, dif_re, dif_im;

    assign rd_addr_a = mema_address;
    assign rd_addr_b = memb_address;

    always_comb begin
        v0_d  = mem_write;
        ma0_d = mema_address;
        mb0_d = memb_address;
        k0_d  = twiddle_address;

        v1_d  = v0_q;
        ma1_d = ma0_q;
        mb1_d = mb0_q;
        a1_d  = rd_data_a;
        b1_d  = rd_data_b;
        twr_d = TW'(ROM_RE[k0_q]) <<< (TW-16);
        twi_d = TW'(ROM_IM[k0_q]) <<< (TW-16);

        v2_d  = v1_q;
        ma2_d = ma1_q;
        mb2_d = mb1_q;
        a2_d  = a1_q;
        prr_d = (DW+TW)'($signed(b1_q[2*DW-1:DW])) * (DW+TW)'(twr_q);
        pii_d = (DW+TW)'($signed(b1_q[DW-1:0]))    * (DW+TW)'(twi_q);
        pri_d = (DW+TW)'($signed(b1_q[2*DW-1:DW])) * (DW+TW)'(twi_q);
        pir_d = (DW+TW)'($signed(b1_q[DW-1:0]))    * (DW+TW)'(twr_q);

        // Round half up, then drop the Q1.(TW-1) fraction
        t_re = (DW+2)'(((DW+TW+1)'(prr_q) - (DW+TW+1)'(pii_q) + RND) >>> (TW-1));
        t_im = (DW+2)'(((DW+TW+1)'(pri_q) + (DW+TW+1)'(pir_q) + RND) >>> (TW-1));
        sum_re = (DW+2)'($signed(a2_q[2*DW-1:DW])) + t_re;
        sum_im = (DW+2)'($signed(a2_q[DW-1:0]))    + t_im;
        dif_re = (DW+2)'($signed(a2_q[2*DW-1:DW])) - t_re;
        dif_im = (DW+2)'($signed(a2_q[DW-1:0]))    - t_im;

        wr_en_d     = v2_q;
        wr_addr_a_d = wr_addr_a_q;
        wr_addr_b_d = wr_addr_b_q;
        wr_data_a_d = wr_data_a_q;
        wr_data_b_d = wr_data_b_q;
        if (v2_q) begin
            wr_addr_a_d = ma2_q;
            wr_addr_b_d = mb2_q;
            wr_data_a_d = {DW'(sum_re >>> SH), DW'(sum_im >>> SH)};
            wr_data_b_d = {DW'(dif_re >>> SH), DW'(dif_im >>> SH)};
        end
    end

    assign fd_rise = fft_done & ~fft_done_q;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        fft_done_d  = fft_done;
        case (state_q)
            IDLE: begin
                drain_cnt_d = 2'd0;
                if (mem_write) state_d = fd_rise ? DRAIN : RUN;
            end
            RUN: begin
                drain_cnt_d = 2'd0;
                if (fd_rise) state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt_q == 2'd3) state_d = DONE;
                else drain_cnt_d = drain_cnt_q + 2'd1;
            end
            DONE:    state_d = mem_write ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drain_cnt_q <= 2'd0;
            fft_done_q  <= 1'b0;
            v0_q <= 1'b0; v1_q <= 1'b0; v2_q <= 1'b0; wr_en_q <= 1'b0;
            ma0_q <= '0; mb0_q <= '0; k0_q <= '0;
            ma1_q <= '0; mb1_q <= '0; a1_q <= '0; b1_q <= '0;
            twr_q <= '0; twi_q <= '0;
            ma2_q <= '0; mb2_q <= '0; a2_q <= '0;
            prr_q <= '0; pii_q <= '0; pri_q <= '0; pir_q <= '0;
            wr_addr_a_q <= '0; wr_addr_b_q <= '0;
            wr_data_a_q <= '0; wr_data_b_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            fft_done_q  <= fft_done_d;
            v0_q <= v0_d; v1_q <= v1_d; v2_q <= v2_d; wr_en_q <= wr_en_d;
            ma0_q <= ma0_d; mb0_q <= mb0_d; k0_q <= k0_d;
            ma1_q <= ma1_d; mb1_q <= mb1_d; a1_q <= a1_d; b1_q <= b1_d;
            twr_q <= twr_d; twi_q <= twi_d;
            ma2_q <= ma2_d; mb2_q <= mb2_d; a2_q <= a2_d;
            prr_q <= prr_d; pii_q <= pii_d; pri_q <= pri_d; pir_q <= pir_d;
            wr_addr_a_q <= wr_addr_a_d; wr_addr_b_q <= wr_addr_b_d;
            wr_data_a_q <= wr_data_a_d; wr_data_b_q <= wr_data_b_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr_a = wr_addr_a_q;
    assign wr_addr_b = wr_addr_b_q;
    assign wr_data_a = wr_data_a_q;
    assign wr_data_b = wr_data_b_q;
    assign busy      = v0_q | v1_q | v2_q | wr_en_q | (state_q == DRAIN);
    assign done      = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_fft_butterfly_datapath.sv
`default_nettype none
// ============================================================================
// tb_fft_butterfly_datapath : randomized bench with a real-arithmetic
// butterfly model and a registered RAM model. Revision 1.0
// ============================================================================
module tb_fft_butterfly_datapath;
    logic        clk, rst_n;
    logic [4:0]  mema_address, memb_address;
    logic [3:0]  twiddle_address;
    logic        mem_write, fft_done;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        wr_en;
    logic [4:0]  wr_addr_a, wr_addr_b;
    logic [31:0] wr_data_a, wr_data_b;
    logic        busy, done;

    logic [31:0] ram [32];
    int checks, errors;

    fft_butterfly_datapath #(.DW(16), .TW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .mema_address(mema_address), .memb_address(memb_address),
        .twiddle_address(twiddle_address), .mem_write(mem_write), .fft_done(fft_done),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data_a <= ram[rd_addr_a];
        rd_data_b <= ram[rd_addr_b];
    end

    function automatic real round_ha(input real x);
        if (x >= 0.0) return $floor(x + 0.5);
        return -$floor(-x + 0.5);
    endfunction

    function automatic real twiddle(input int k, input bit im);
        real ang, v;
        ang = 2.0 * 3.141592653589793 * k / 32.0;
        v = im ? round_ha(-32768.0 * $sin(ang)) : round_ha(32767.0 * $cos(ang));
        if (v > 32767.0) v = 32767.0;
        if (v < -32768.0) v = -32768.0;
        return v;
    endfunction

    function automatic real reduce(input real x);
`ifdef FFT_BFLY_SCALE_EN
        return $floor(x / 2.0);
`else
        return x;
`endif
    endfunction

    function automatic logic [15:0] wrap16(input real x);
        longint v;
        v = longint'(x);
        return v[15:0];
    endfunction

    // Returns {A', B'} as {re,im,re,im}
    function automatic logic [63:0] bfly_model(input logic [31:0] a, input logic [31:0] b, input int k);
        real ar, ai, br, bi, wr, wi, tre, tim;
        ar = $itor($signed(a[31:16])); ai = $itor($signed(a[15:0]));
        br = $itor($signed(b[31:16])); bi = $itor($signed(b[15:0]));
        wr = twiddle(k, 1'b0); wi = twiddle(k, 1'b1);
        tre = $floor((br * wr - bi * wi + 16384.0) / 32768.0);
        tim = $floor((br * wi + bi * wr + 16384.0) / 32768.0);
        return {wrap16(reduce(ar + tre)), wrap16(reduce(ai + tim)),
                wrap16(reduce(ar - tre)), wrap16(reduce(ai - tim))};
    endfunction

    task automatic fire(input logic [4:0] ma, input logic [4:0] mb, input logic [3:0] k, input logic fd);
        mema_address = ma; memb_address = mb; twiddle_address = k;
        mem_write = 1'b1; fft_done = fd;
        @(posedge clk); #1;
        mem_write = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (4) begin
            mema_address = 5'($urandom); memb_address = 5'($urandom);
            twiddle_address = 4'($urandom); mem_write = 1'($urandom); fft_done = 1'($urandom);
            @(posedge clk); #1;
        end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if ({wr_data_a, wr_data_b} !== 64'd0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", {wr_data_a, wr_data_b}); end
        checks++; if ({wr_addr_a, wr_addr_b} !== 10'd0) begin errors++; $display("FAIL reset_wr_addr: got %h expected 0", {wr_addr_a, wr_addr_b}); end
        checks++; if ({rd_addr_a, rd_addr_b} !== {mema_address, memb_address}) begin
            errors++; $display("FAIL rd_addr_passthru: got %h expected %h", {rd_addr_a, rd_addr_b}, {mema_address, memb_address}); end
        mem_write = 1'b0; fft_done = 1'b0; rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            checks++; if ({wr_en, busy, done} !== 3'b000) begin errors++; $display("FAIL idle_after_reset: got %b expected 000", {wr_en, busy, done}); end
        end
    endtask

    task automatic test_mid_reset;
        ram[7] = $urandom; ram[23] = $urandom;
        fire(5'd7, 5'd23, 4'($urandom), 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL mid_reset_flush: got %b expected 0", wr_en); end
        end
    endtask

    task automatic test_isolated;
        logic [31:0] a, b, held;
        logic [3:0]  k;
        logic [4:0]  ma, mb;
        logic [63:0] exp_d;
        for (int i = 0; i < 13; i++) begin
            case (i)
                0: begin a = {16'd1000, 16'd0};   b = {16'd200, 16'd0};    k = 4'd0; end
                1: begin a = 32'd0;               b = {16'd1000, 16'd0};   k = 4'd8; end
                2: begin a = {16'd32767, 16'd32767}; b = a;                k = 4'd0; end
                default: begin a = $urandom; b = $urandom; k = 4'($urandom_range(15, 0)); end
            endcase
            ma = 5'($urandom); mb = ma ^ 5'd16;
            ram[ma] = a; ram[mb] = b;
            exp_d = bfly_model(a, b, int'(k));
            fire(ma, mb, k, 1'b0);
            @(posedge clk); #1;
            @(posedge clk); #1;
            checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL latency_early[%0d]: got %b expected 0", i, wr_en); end
            @(posedge clk); #1;
            checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL latency_wr_en[%0d]: got %b expected 1", i, wr_en); end
            checks++; if ({wr_addr_a, wr_addr_b} !== {ma, mb}) begin
                errors++; $display("FAIL isolated_addr[%0d]: got %h expected %h", i, {wr_addr_a, wr_addr_b}, {ma, mb}); end
            checks++; if ({wr_data_a, wr_data_b} !== exp_d) begin
                errors++; $display("FAIL isolated_data[%0d] k=%0d: got %h expected %h", i, k, {wr_data_a, wr_data_b}, exp_d); end
            held = wr_data_a;
            @(posedge clk); #1;
            checks++; if ({wr_en, wr_data_a} !== {1'b0, exp_d[63:32]}) begin
                errors++; $display("FAIL hold[%0d]: got %b/%h expected 0/%h", i, wr_en, wr_data_a, held); end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  ks [16];
        logic [63:0] exp_q [16];
        int j;
        for (int i = 0; i < 16; i++) begin
            ram[i] = $urandom; ram[i + 16] = $urandom;
            ks[i] = 4'($urandom_range(15, 0));
            exp_q[i] = bfly_model(ram[i], ram[i + 16], int'(ks[i]));
        end
        for (int i = 0; i < 19; i++) begin
            if (i < 16) begin
                mema_address = 5'(i); memb_address = 5'(i + 16);
                twiddle_address = ks[i]; mem_write = 1'b1;
            end else begin
                mem_write = 1'b0;
            end
            @(posedge clk); #1;
            if (i >= 3) begin
                j = i - 3;
                checks++; if ({wr_en, wr_addr_a, wr_addr_b} !== {1'b1, 5'(j), 5'(j + 16)}) begin
                    errors++; $display("FAIL b2b_addr[%0d]: got %b/%h/%h expected 1/%h/%h", j, wr_en, wr_addr_a, wr_addr_b, 5'(j), 5'(j + 16)); end
                checks++; if ({wr_data_a, wr_data_b} !== exp_q[j]) begin
                    errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", j, {wr_data_a, wr_data_b}, exp_q[j]); end
            end
        end
        @(posedge clk); #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", wr_en); end
    endtask

    task automatic test_completion;
        logic [3:0]  k;
        logic [63:0] exp_d;
        int pulses;
        k = 4'($urandom_range(15, 0));
        ram[3] = $urandom; ram[19] = $urandom;
        exp_d = bfly_model(ram[3], ram[19], int'(k));
        pulses = 0;
        mema_address = 5'd3; memb_address = 5'd19; twiddle_address = k;
        mem_write = 1'b1; fft_done = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            mem_write = 1'b0;
            if (done === 1'b1) pulses++;
            checks++; if ({wr_en, busy, done} !== {e == 4, e <= 4, e == 5}) begin
                errors++; $display("FAIL completion_flags[%0d]: got %b expected %b", e, {wr_en, busy, done}, {e == 4, e <= 4, e == 5}); end
            if (e == 4) begin
                checks++; if ({wr_data_a, wr_data_b} !== exp_d) begin
                    errors++; $display("FAIL completion_data: got %h expected %h", {wr_data_a, wr_data_b}, exp_d); end
            end
        end
        fft_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL done_pulses: got %0d expected 1", pulses); end
    endtask

    initial begin
        checks = 0; errors = 0;
        clk = 1'b0; rst_n = 1'b0;
        mema_address = '0; memb_address = '0; twiddle_address = '0;
        mem_write = 1'b0; fft_done = 1'b0;
        for (int i = 0; i < 32; i++) ram[i] = 32'd0;
        #1;
        test_reset;
        test_mid_reset;
        test_isolated;
        test_back_to_back;
        test_completion;
        test_isolated;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
